// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Instruction memory placed in front of the core's IF stage. After reset it
// fills every word with NOP. It then takes a program image as a valid/ready
// word stream, and only after that does it release the core and serve fetches.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous reset, active-high
//   ld_valid     loader word valid
//   ld_ready     loader word accepted when ld_valid & ld_ready
//   ld_data      instruction word, written to the next sequential index
//   ld_last      marks the final word of the image
//   boot_req     reload request (honoured only in RUN)
//   cs_i_n       fetch chip-select from the core, active-low
//   i_addr       byte fetch address from the core
//   i_data       fetched instruction (NOP when the fetch is not valid)
//   core_rst_n   reset to the core, active-low (low unless in RUN)
//   load_done    high in RUN
//   load_count   words accepted in the current or last load
//   err_overflow image filled DEPTH words without ld_last
module imem_boot_loader #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              boot_req,
  input  logic              cs_i_n,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_data,
  output logic              core_rst_n,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_clrIdx;
  logic [ADDR_W:0]     r_loadCount;
  logic                r_errOverflow;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_lastSlot;
  logic                w_fetchOk;

  // The count can never actually reach DEPTH while in LOAD (that accept moves
  // to RUN), but the compare keeps ready honest if that ever changes.
  assign ld_ready   = (r_state == LOAD) && (r_loadCount < DEPTH_CNT);
  assign w_accept   = ld_valid && ld_ready;
  assign w_lastSlot = (r_loadCount == LAST_CNT);

  // Next-state logic: CLEAR sweeps the whole array, LOAD ends on ld_last or
  // when the array is full, RUN leaves only on a reload request.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CLEAR: begin
        if (r_clrIdx == LAST_IDX) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        if (w_accept && (ld_last || w_lastSlot)) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (boot_req) begin
          w_nextState = CLEAR;
        end
      end
      default: begin
        w_nextState = CLEAR;
      end
    endcase
  end

  // State, clear index, load count and the overflow flag. A boot request
  // rewinds the same counters that reset does, so the reload is identical to
  // a fresh boot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CLEAR;
      r_clrIdx      <= '0;
      r_loadCount   <= '0;
      r_errOverflow <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        CLEAR: begin
          r_clrIdx <= r_clrIdx + 1'b1;
        end
        LOAD: begin
          if (w_accept) begin
            r_loadCount <= r_loadCount + 1'b1;
            if (w_lastSlot && !ld_last) begin
              r_errOverflow <= 1'b1;
            end
          end
        end
        RUN: begin
          if (boot_req) begin
            r_clrIdx      <= '0;
            r_loadCount   <= '0;
            r_errOverflow <= 1'b0;
          end
        end
        default: begin
          r_clrIdx <= '0;
        end
      endcase
    end
  end

  // Single write port. Writes happen only in CLEAR and LOAD, so they never
  // collide with a fetch, which is served only in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_clrIdx] <= NOP_WORD;
      end else if (w_accept) begin
        r_mem[r_loadCount[ADDR_W-1:0]] <= ld_data;
      end
    end
  end

  // A fetch is honoured only when it is word-aligned and inside the array.
  // Everything else, including fetches outside RUN, returns NOP.
  assign w_fetchOk = (r_state == RUN) && !cs_i_n && (i_addr[1:0] == 2'b00) &&
                     (i_addr[31:ADDR_W+2] == '0);
  assign i_data = w_fetchOk ? r_mem[i_addr[ADDR_W+1:2]] : NOP_WORD;

  // Both outputs come straight from the state register, so they are glitch-free.
  assign core_rst_n   = (r_state == RUN);
  assign load_done    = (r_state == RUN);
  assign load_count   = r_loadCount;
  assign err_overflow = r_errOverflow;

endmodule
